// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-issue scheduler: instruction buffer, pairing rules, divider serialisation.
// Optional macro DUAL_ISSUE_EN enables pair issue from the head+1 entry on lane 1.
module issue_scheduler #(
    parameter int         DEPTH      = 4,
    parameter int         TAG_W      = 32,
    parameter logic [2:0] FWD_MASK   = 3'b011,
    parameter int         DIV_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic [1:0]            dec_valid,
    input  logic [1:0][4:0]       dec_src_a,
    input  logic [1:0][4:0]       dec_src_b,
    input  logic [1:0][4:0]       dec_dest,
    input  logic [1:0]            dec_wen,
    input  logic [1:0][1:0]       dec_cls,
    input  logic [1:0][TAG_W-1:0] dec_tag,
    output logic                  dec_ready,
    output logic [3:0][4:0]       sb_read_addr,
    input  logic [3:0][2:0]       sb_data_out,
    output logic [1:0]            sb_write_ena,
    output logic [1:0][4:0]       sb_write_addr,
    output logic [1:0][2:0]       sb_data_in,
    output logic                  sb_flash,
    output logic [1:0]            iss_valid,
    output logic [1:0][4:0]       iss_src_a,
    output logic [1:0][4:0]       iss_src_b,
    output logic [1:0][4:0]       iss_dest,
    output logic [1:0]            iss_wen,
    output logic [1:0][1:0]       iss_cls,
    output logic [1:0][TAG_W-1:0] iss_tag,
    output logic                  div_busy
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam int         CNT_W   = $clog2(DEPTH + 1);
    localparam int         CYC_W   = $clog2(DIV_CYCLES);
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_DIV = 2'b10;
    localparam logic [1:0] CLS_BR  = 2'b11;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]       src_a;
        logic [4:0]       src_b;
        logic [4:0]       dest;
        logic             wen;
        logic [1:0]       cls;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} div_state_t;

    entry_t           entries [DEPTH];
    entry_t           slot    [2];
    entry_t           in0;
    entry_t           in1;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;
    logic [CNT_W-1:0] count;
    logic             valid0;
    logic             valid1;
    logic             ready0;
    logic             ready1;
    logic             raw;
    logic             pair_ok;
    logic             fsm_ok0;
    logic [1:0]       iss;
    logic [1:0]       n_pop;
    logic [1:0]       n_push;
    div_state_t       state;
    div_state_t       state_next;
    logic [CYC_W-1:0] div_cnt;
    logic [CYC_W-1:0] div_cnt_next;

    // A producer already in a forwardable stage counts as ready for its consumer.
    function automatic logic op_ready(input logic [4:0] addr, input logic [2:0] pos);
        return (addr == 5'd0) || (pos == 3'd0) || ((pos & FWD_MASK) != 3'd0);
    endfunction

    assign head1   = head + 1'b1;
    assign tail1   = tail + 1'b1;
    assign slot[0] = entries[head];
    assign slot[1] = entries[head1];
    assign in0     = {dec_src_a[0], dec_src_b[0], dec_dest[0], dec_wen[0], dec_cls[0], dec_tag[0]};
    assign in1     = {dec_src_a[1], dec_src_b[1], dec_dest[1], dec_wen[1], dec_cls[1], dec_tag[1]};

    assign dec_ready = (count <= CNT_W'(DEPTH - 2));
    assign valid0    = (count != '0);
    assign valid1    = (count > CNT_W'(1));

    assign sb_read_addr = {slot[1].src_b, slot[1].src_a, slot[0].src_b, slot[0].src_a};
    assign sb_data_in   = {3'b100, 3'b100};
    assign sb_flash     = flush;

    assign ready0 = op_ready(slot[0].src_a, sb_data_out[0]) && op_ready(slot[0].src_b, sb_data_out[1]);
    assign ready1 = op_ready(slot[1].src_a, sb_data_out[2]) && op_ready(slot[1].src_b, sb_data_out[3]);

    assign raw = slot[0].wen && (slot[0].dest != 5'd0) &&
                 ((slot[0].dest == slot[1].src_a) || (slot[0].dest == slot[1].src_b));

    assign pair_ok = valid1 && ready1 && !raw &&
                     !((slot[0].cls == CLS_MEM) && (slot[1].cls == CLS_MEM)) &&
                     (slot[0].cls != CLS_BR) && (slot[1].cls != CLS_DIV);

    assign iss[0] = valid0 && ready0 && !stall && fsm_ok0;
    assign iss[1] = DUAL && iss[0] && pair_ok;

    assign n_pop  = {1'b0, iss[0]} + {1'b0, iss[1]};
    assign n_push = dec_ready ? ({1'b0, dec_valid[0]} + {1'b0, dec_valid[0] & dec_valid[1]}) : 2'd0;

    always_ff @(posedge clk) begin
        if (!flush && (n_push != 2'd0)) begin
            entries[tail] <= in0;
            if (n_push == 2'd2) begin
                entries[tail1] <= in1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    // Issued fields hold across idle/stalled cycles; only the valid bits drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid     <= '0;
            sb_write_ena  <= '0;
            sb_write_addr <= '0;
            iss_src_a     <= '0;
            iss_src_b     <= '0;
            iss_dest      <= '0;
            iss_wen       <= '0;
            iss_cls       <= '0;
            iss_tag       <= '0;
        end else if (flush) begin
            iss_valid    <= '0;
            sb_write_ena <= '0;
        end else begin
            iss_valid <= iss;
            for (int l = 0; l < 2; l++) begin
                sb_write_ena[l] <= iss[l] && slot[l].wen && (slot[l].dest != 5'd0);
                if (iss[l]) begin
                    sb_write_addr[l] <= slot[l].dest;
                    iss_src_a[l]     <= slot[l].src_a;
                    iss_src_b[l]     <= slot[l].src_b;
                    iss_dest[l]      <= slot[l].dest;
                    iss_wen[l]       <= slot[l].wen;
                    iss_cls[l]       <= slot[l].cls;
                    iss_tag[l]       <= slot[l].tag;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        if (flush) begin
            state_next   = S_IDLE;
            div_cnt_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iss[0] && (slot[0].cls == CLS_DIV)) begin
                        state_next   = S_BUSY;
                        div_cnt_next = CYC_W'(DIV_CYCLES - 1);
                    end
                end
                S_BUSY: begin
                    if (div_cnt == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        div_cnt_next = div_cnt - 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        div_busy = (state != S_IDLE);
        fsm_ok0  = (state == S_IDLE) || ((slot[0].cls != CLS_DIV) && (state != S_BUSY));
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - self-checking bench for issue_scheduler against a queue-level issue model.
module tb_issue_scheduler;
    localparam int         DEPTH      = 4;
    localparam int         TAG_W      = 32;
    localparam int         DIV_CYCLES = 16;
    localparam logic [2:0] FWD_MASK   = 3'b011;
`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] MEM = 2'b01;
    localparam logic [1:0] DIV = 2'b10;
    localparam logic [1:0] BR  = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  stall;
    logic [1:0]            dec_valid;
    logic [1:0][4:0]       dec_src_a;
    logic [1:0][4:0]       dec_src_b;
    logic [1:0][4:0]       dec_dest;
    logic [1:0]            dec_wen;
    logic [1:0][1:0]       dec_cls;
    logic [1:0][TAG_W-1:0] dec_tag;
    logic                  dec_ready;
    logic [3:0][4:0]       sb_read_addr;
    logic [3:0][2:0]       sb_data_out;
    logic [1:0]            sb_write_ena;
    logic [1:0][4:0]       sb_write_addr;
    logic [1:0][2:0]       sb_data_in;
    logic                  sb_flash;
    logic [1:0]            iss_valid;
    logic [1:0][4:0]       iss_src_a;
    logic [1:0][4:0]       iss_src_b;
    logic [1:0][4:0]       iss_dest;
    logic [1:0]            iss_wen;
    logic [1:0][1:0]       iss_cls;
    logic [1:0][TAG_W-1:0] iss_tag;
    logic                  div_busy;

    issue_scheduler #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .FWD_MASK(FWD_MASK), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
        .dec_dest(dec_dest), .dec_wen(dec_wen), .dec_cls(dec_cls), .dec_tag(dec_tag),
        .dec_ready(dec_ready), .sb_read_addr(sb_read_addr), .sb_data_out(sb_data_out),
        .sb_write_ena(sb_write_ena), .sb_write_addr(sb_write_addr), .sb_data_in(sb_data_in),
        .sb_flash(sb_flash), .iss_valid(iss_valid), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .iss_dest(iss_dest), .iss_wen(iss_wen), .iss_cls(iss_cls), .iss_tag(iss_tag),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       a;
        logic [4:0]       b;
        logic [4:0]       d;
        logic             w;
        logic [1:0]       c;
        logic [TAG_W-1:0] tag;
    } ins_t;

    ins_t       q[$];
    ins_t       exp_iss [2];
    ins_t       nop;
    int         div_left = 0;
    logic [1:0] exp_iv;
    logic [1:0] exp_we;
    logic [2:0] pos [32];
    int         checks = 0;
    int         errors = 0;

    always_comb begin
        for (int i = 0; i < 4; i++) sb_data_out[i] = pos[sb_read_addr[i]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                                input logic [1:0] c, input logic w = 1'b1);
        ins_t x;
        x.a = a; x.b = b; x.d = d; x.w = w; x.c = c;
        x.tag = 32'hC0DE_0000 | 32'({c, d, a, b});
        return x;
    endfunction

    function automatic bit op_ok(input logic [4:0] r);
        return (r == 5'd0) || (pos[r] == 3'd0) || ((pos[r] & FWD_MASK) != 3'd0);
    endfunction

    function automatic bit src_ok(input ins_t x);
        return op_ok(x.a) && op_ok(x.b);
    endfunction

    function automatic bit pair_ok(input ins_t x, input ins_t y);
        if (x.w && (x.d != 5'd0) && ((x.d == y.a) || (x.d == y.b))) return 1'b0;
        if ((x.c == MEM) && (y.c == MEM)) return 1'b0;
        if ((x.c == BR) || (y.c == DIV)) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive, check combinational outputs, predict, clock, check registered outputs.
    task automatic step(input logic [1:0] dv, input ins_t l0, input ins_t l1, input logic st, input logic fl);
        ins_t lane [2];
        int   n;
        bit   rdy;
        lane[0] = l0;
        lane[1] = l1;
        dec_valid = dv; stall = st; flush = fl;
        for (int i = 0; i < 2; i++) begin
            dec_src_a[i] = lane[i].a; dec_src_b[i] = lane[i].b; dec_dest[i] = lane[i].d;
            dec_wen[i] = lane[i].w; dec_cls[i] = lane[i].c; dec_tag[i] = lane[i].tag;
        end
        #1;
        rdy = (q.size() <= DEPTH - 2);
        chk("dec_ready", 64'(dec_ready), 64'(rdy));
        chk("sb_flash", 64'(sb_flash), 64'(fl));
        for (int i = 0; i < 2 && i < q.size(); i++)
            chk("sb_read_addr", 64'({sb_read_addr[2*i+1], sb_read_addr[2*i]}), 64'({q[i].b, q[i].a}));
        n = 0;
        if (!fl && !st && (div_left == 0) && (q.size() >= 1) && src_ok(q[0])) begin
            n = 1;
            if (DUAL && (q.size() >= 2) && src_ok(q[1]) && pair_ok(q[0], q[1])) n = 2;
        end
        @(posedge clk);
        #1;
        exp_iv = '0;
        exp_we = '0;
        if (fl) begin
            q.delete();
            div_left = 0;
        end else begin
            if (div_left > 0) div_left--;
            for (int i = 0; i < n; i++) begin
                exp_iss[i] = q.pop_front();
                exp_iv[i]  = 1'b1;
                exp_we[i]  = exp_iss[i].w && (exp_iss[i].d != 5'd0);
                if (exp_iss[i].c == DIV) div_left = DIV_CYCLES;
            end
            if (rdy) begin
                for (int i = 0; i < 2; i++) if (dv[i] && dv[0]) q.push_back(lane[i]);
            end
        end
        chk("iss_valid", 64'(iss_valid), 64'(exp_iv));
        chk("sb_write_ena", 64'(sb_write_ena), 64'(exp_we));
        chk("div_busy", 64'(div_busy), 64'(div_left > 0));
        chk("sb_data_in", 64'(sb_data_in), 64'(6'b100100));
        for (int i = 0; i < 2; i++) begin
            if (exp_iv[i])
                chk("iss_lane", 64'({iss_src_a[i], iss_src_b[i], iss_dest[i], iss_wen[i], iss_cls[i], iss_tag[i]}),
                    64'({exp_iss[i].a, exp_iss[i].b, exp_iss[i].d, exp_iss[i].w, exp_iss[i].c, exp_iss[i].tag}));
            if (exp_we[i])
                chk("sb_write_addr", 64'(sb_write_addr[i]), 64'(exp_iss[i].d));
        end
    endtask

    task automatic idle(input int k = 1);
        repeat (k) step(2'b00, nop, nop, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (((q.size() != 0) || (div_left != 0)) && (k < 60)) begin
            idle();
            k++;
        end
        chk("drain_idle", 64'({div_busy, dec_ready}), 64'(2'b01));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int   busy_n;
        int   k;
        ins_t pa [6];
        ins_t pb [6];
        logic [1:0] pexp [6];

        for (int i = 0; i < 32; i++) pos[i] = 3'd0;
        nop = mk(5'd0, 5'd0, 5'd0, ALU, 1'b0);
        rst = 1'b1; flush = 1'b0; stall = 1'b0; dec_valid = '0;
        dec_src_a = '0; dec_src_b = '0; dec_dest = '0; dec_wen = '0; dec_cls = '0; dec_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_state", 64'({iss_valid, sb_write_ena, dec_ready, div_busy}), 64'(6'b000010));

        // independent ALU pair r1<=r2, r3<=r4
        step(2'b11, mk(5'd1, 5'd2, 5'd0, ALU), mk(5'd3, 5'd4, 5'd0, ALU), 1'b0, 1'b0);
        idle();
        chk("t1_iss_valid", 64'(iss_valid), 64'(DUAL ? 2'b11 : 2'b01));
        chk("t1_sb_wen", 64'(sb_write_ena), 64'(DUAL ? 2'b11 : 2'b01));
        chk("t1_addr0", 64'(sb_write_addr[0]), 64'(5'd1));
        idle();
        chk("t1_second", 64'({iss_valid, iss_dest[0]}), 64'(DUAL ? {2'b00, 5'd1} : {2'b01, 5'd3}));

        // RAW pair r5<=r1, r6<=r5, then wait for a forwardable position
        step(2'b11, mk(5'd5, 5'd1, 5'd0, ALU), mk(5'd6, 5'd5, 5'd0, ALU), 1'b0, 1'b0);
        idle();
        chk("t2_lane0_only", 64'({iss_valid, iss_dest[0]}), 64'({2'b01, 5'd5}));
        pos[5] = 3'b100;
        idle(3);
        chk("t2_hold", 64'(iss_valid), 64'(2'b00));
        pos[5] = 3'b010;
        idle();
        chk("t2_fwd_issue", 64'({iss_valid, iss_dest[0]}), 64'({2'b01, 5'd6}));
        pos[5] = 3'd0;

        // divider serialisation
        step(2'b01, mk(5'd7, 5'd1, 5'd2, DIV), nop, 1'b0, 1'b0);
        step(2'b01, mk(5'd8, 5'd1, 5'd0, ALU), nop, 1'b0, 1'b0);
        chk("t3_div_issue", 64'({div_busy, iss_valid, iss_cls[0]}), 64'({1'b1, 2'b01, DIV}));
        busy_n = 1;
        k = 0;
        while (div_busy && (k < 40)) begin
            idle();
            if (div_busy) busy_n++;
            k++;
        end
        chk("t3_busy_cycles", 64'(busy_n), 64'(16));
        idle();
        chk("t3_alu_after", 64'({iss_valid, iss_dest[0]}), 64'({2'b01, 5'd8}));

        // fill under stall, then release
        step(2'b11, mk(5'd9, 5'd0, 5'd0, ALU), mk(5'd10, 5'd0, 5'd0, ALU), 1'b1, 1'b0);
        chk("t4_ready_cnt2", 64'(dec_ready), 64'(1'b1));
        step(2'b11, mk(5'd11, 5'd0, 5'd0, ALU), mk(5'd12, 5'd0, 5'd0, ALU), 1'b1, 1'b0);
        chk("t4_full", 64'(dec_ready), 64'(1'b0));
        step(2'b11, mk(5'd13, 5'd0, 5'd0, ALU), mk(5'd14, 5'd0, 5'd0, ALU), 1'b1, 1'b0);
        idle();
        chk("t4_release", 64'({iss_valid, dec_ready}), 64'(DUAL ? 3'b111 : 3'b010));
        drain();

        // flush mid-DIV with three buffered entries
        step(2'b01, mk(5'd7, 5'd1, 5'd2, DIV), nop, 1'b0, 1'b0);
        step(2'b11, mk(5'd20, 5'd1, 5'd0, ALU), mk(5'd21, 5'd2, 5'd0, ALU), 1'b0, 1'b0);
        step(2'b01, mk(5'd22, 5'd3, 5'd0, ALU), nop, 1'b0, 1'b0);
        chk("t5_pre", 64'({div_busy, dec_ready}), 64'(2'b10));
        step(2'b00, nop, nop, 1'b0, 1'b1);
        chk("t5_flush", 64'({div_busy, iss_valid, dec_ready}), 64'(4'b0001));
        step(2'b11, mk(5'd23, 5'd0, 5'd0, ALU), mk(5'd24, 5'd0, 5'd0, ALU), 1'b0, 1'b1);
        idle(2);
        chk("t5_dropped", 64'({iss_valid, dec_ready}), 64'(3'b001));

        // pairing rules
        pa[0] = mk(5'd13, 5'd1, 5'd0, MEM);        pb[0] = mk(5'd14, 5'd2, 5'd0, MEM);  pexp[0] = 2'b01;
        pa[1] = mk(5'd0, 5'd1, 5'd2, BR, 1'b0);    pb[1] = mk(5'd15, 5'd1, 5'd0, ALU);  pexp[1] = 2'b01;
        pa[2] = mk(5'd16, 5'd1, 5'd0, ALU);        pb[2] = mk(5'd17, 5'd2, 5'd3, DIV);  pexp[2] = 2'b01;
        pa[3] = mk(5'd18, 5'd1, 5'd0, ALU);        pb[3] = mk(5'd18, 5'd2, 5'd0, ALU);  pexp[3] = DUAL ? 2'b11 : 2'b01;
        pa[4] = mk(5'd5, 5'd1, 5'd0, ALU, 1'b0);   pb[4] = mk(5'd19, 5'd5, 5'd0, ALU);  pexp[4] = DUAL ? 2'b11 : 2'b01;
        pa[5] = mk(5'd0, 5'd1, 5'd0, ALU);         pb[5] = mk(5'd25, 5'd0, 5'd0, MEM);  pexp[5] = DUAL ? 2'b11 : 2'b01;
        for (int i = 0; i < 6; i++) begin
            step(2'b11, pa[i], pb[i], 1'b0, 1'b0);
            idle();
            chk("t6_pair_valid", 64'(iss_valid), 64'(pexp[i]));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
